// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus used by the MEM stage.
// The master side issues registered requests; the slave side answers with ack/rdata.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: multi-cycle data-memory access with stall
// and timeout, branch/jump redirect resolution, and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWrite_in,
  input  logic [1:0]           MemtoReg_in,
  input  logic                 Branch_in,
  input  logic                 MemRead_in,
  input  logic                 MemWrite_in,
  input  logic                 Jump_in,
  input  logic [31:0]          jump_addr_in,
  input  logic [31:0]          branch_addr_in,
  input  logic [31:0]          PC_plus_4_in,
  input  logic                 ALU_zero_in,
  input  logic [31:0]          ALU_result_in,
  input  logic [31:0]          reg_read_data_2_in,
  input  logic [4:0]           EX_MEM_RegisterRd_in,
  mem_access_stage_if.master   dmem,
  output logic                 mem_stall,
  output logic                 PCSrc,
  output logic [31:0]          PC_target,
  output logic                 EX_Flush,
  output logic                 bus_error,
  output logic                 RegWrite_out,
  output logic [1:0]           MemtoReg_out,
  output logic [31:0]          ALU_result_out,
  output logic [31:0]          mem_read_data_out,
  output logic [31:0]          PC_plus_4_out,
  output logic [4:0]           MEM_WB_RegisterRd_out
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;

  logic        mem_op;
  logic        misaligned;
  logic        issue;
  logic        drop_req;
  logic        set_err;
  logic        cnt_inc;
  logic        wb_take;
  logic [31:0] wb_rdata;

  assign mem_op     = MemRead_in | MemWrite_in;
  assign misaligned = mem_op & (ALU_result_in[1:0] != 2'b00);

  assign PC_target = Jump_in ? jump_addr_in : branch_addr_in;
  assign EX_Flush  = PCSrc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    PCSrc      = 1'b0;
    issue      = 1'b0;
    drop_req   = 1'b0;
    set_err    = 1'b0;
    cnt_inc    = 1'b0;
    wb_take    = 1'b0;
    wb_rdata   = '0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          wb_take = 1'b1;
          PCSrc   = Jump_in | (Branch_in & ALU_zero_in);
        end else if (misaligned) begin
          set_err = 1'b1;
        end else begin
          mem_stall  = 1'b1;
          issue      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // An ack arriving in the final allowed cycle completes rather than aborts.
        if (dmem.dmem_ack) begin
          wb_take    = 1'b1;
          wb_rdata   = dmem.dmem_rdata;
          drop_req   = 1'b1;
          state_next = IDLE;
        end else if (count == CNT_LAST) begin
          drop_req   = 1'b1;
          set_err    = 1'b1;
          state_next = IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count           <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      bus_error       <= 1'b0;
    end else begin
      if (issue) begin
        count           <= '0;
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= MemWrite_in & ~MemRead_in;
        dmem.dmem_addr  <= ALU_result_in;
        dmem.dmem_wdata <= reg_read_data_2_in;
      end else begin
        if (cnt_inc) begin
          count <= count + 1'b1;
        end
        if (drop_req) begin
          dmem.dmem_req <= 1'b0;
        end
      end
      if (set_err) begin
        bus_error <= 1'b1;
      end
    end
  end

  // Anything other than a completed instruction writes an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite_out          <= 1'b0;
      MemtoReg_out          <= '0;
      ALU_result_out        <= '0;
      mem_read_data_out     <= '0;
      PC_plus_4_out         <= '0;
      MEM_WB_RegisterRd_out <= '0;
    end else if (wb_take) begin
      RegWrite_out          <= RegWrite_in;
      MemtoReg_out          <= MemtoReg_in;
      ALU_result_out        <= ALU_result_in;
      mem_read_data_out     <= wb_rdata;
      PC_plus_4_out         <= PC_plus_4_in;
      MEM_WB_RegisterRd_out <= EX_MEM_RegisterRd_in;
    end else begin
      RegWrite_out          <= 1'b0;
      MemtoReg_out          <= '0;
      ALU_result_out        <= '0;
      mem_read_data_out     <= '0;
      PC_plus_4_out         <= '0;
      MEM_WB_RegisterRd_out <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then randomized instructions, each
// judged by an instruction-level model of stall length, redirect and write-back.
module tb_mem_access_stage;
  localparam int unsigned T = 16;

  logic clk, rst;
  logic RegWrite_in, Branch_in, MemRead_in, MemWrite_in, Jump_in, ALU_zero_in;
  logic [1:0]  MemtoReg_in;
  logic [31:0] jump_addr_in, branch_addr_in, PC_plus_4_in, ALU_result_in, reg_read_data_2_in;
  logic [4:0]  EX_MEM_RegisterRd_in;
  logic mem_stall, PCSrc, EX_Flush, bus_error, RegWrite_out;
  logic [31:0] PC_target, ALU_result_out, mem_read_data_out, PC_plus_4_out;
  logic [1:0]  MemtoReg_out;
  logic [4:0]  MEM_WB_RegisterRd_out;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Jump_in(Jump_in),
    .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .PC_plus_4_in(PC_plus_4_in), .ALU_zero_in(ALU_zero_in), .ALU_result_in(ALU_result_in),
    .reg_read_data_2_in(reg_read_data_2_in), .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in),
    .dmem(dmem.master),
    .mem_stall(mem_stall), .PCSrc(PCSrc), .PC_target(PC_target), .EX_Flush(EX_Flush),
    .bus_error(bus_error), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .ALU_result_out(ALU_result_out), .mem_read_data_out(mem_read_data_out),
    .PC_plus_4_out(PC_plus_4_out), .MEM_WB_RegisterRd_out(MEM_WB_RegisterRd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw, br, mr, mw, j, zero;
    logic [1:0]  mt;
    logic [31:0] jaddr, baddr, pc4, alu, wd;
    logic [4:0]  rd;
  } instr_t;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic        exp_err = 1'b0;
  logic [31:0] dmodel [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (dmodel.exists(a)) return dmodel[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic apply(input instr_t in);
    RegWrite_in = in.rw;   MemtoReg_in = in.mt;   Branch_in = in.br;
    MemRead_in = in.mr;    MemWrite_in = in.mw;   Jump_in = in.j;
    jump_addr_in = in.jaddr; branch_addr_in = in.baddr; PC_plus_4_in = in.pc4;
    ALU_zero_in = in.zero; ALU_result_in = in.alu; reg_read_data_2_in = in.wd;
    EX_MEM_RegisterRd_in = in.rd;
  endtask

  function automatic instr_t nop();
    instr_t n;
    n.rw = 0; n.br = 0; n.mr = 0; n.mw = 0; n.j = 0; n.zero = 0; n.mt = 0;
    n.jaddr = 0; n.baddr = 0; n.pc4 = 0; n.alu = 0; n.wd = 0; n.rd = 0;
    return n;
  endfunction

  // One instruction through MEM; dly = cycles from request rise to ack (memory latency).
  task automatic run_instr(input instr_t in, input int unsigned dly);
    logic memop, mis, acc, wr, pcs, tmo, done;
    int unsigned nstall;
    logic [31:0] rdv, tgt;
    memop  = in.mr | in.mw;
    mis    = memop && (in.alu[1:0] != 2'b00);
    acc    = memop && !mis;
    wr     = in.mw && !in.mr;
    nstall = acc ? ((dly < T) ? dly : T) : 0;
    tmo    = acc && (dly > T);
    done   = !memop || (acc && !tmo);
    pcs    = !memop && (in.j || (in.br && in.zero));
    tgt    = in.j ? in.jaddr : in.baddr;
    rdv    = '0;
    @(negedge clk);
    apply(in);
    for (int unsigned c = 0; c <= nstall; c++) begin
      if (c > 0) @(negedge clk);
      if (acc && c == dly) begin
        rdv = wr ? $urandom : mem_rd(in.alu);
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = rdv;
      end else begin
        dmem.dmem_ack   = (c == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem.dmem_rdata = $urandom;
      end
      #1;
      chk("mem_stall", {31'b0, mem_stall}, {31'b0, c < nstall});
      chk("PCSrc", {31'b0, PCSrc}, {31'b0, c == 0 && pcs});
      chk("EX_Flush", {31'b0, EX_Flush}, {31'b0, c == 0 && pcs});
      if (c == 0) chk("PC_target", PC_target, tgt);
      if (c > 0) begin
        chk("dmem_req", {31'b0, dmem.dmem_req}, 32'd1);
        chk("dmem_we", {31'b0, dmem.dmem_we}, {31'b0, wr});
        chk("dmem_addr", dmem.dmem_addr, in.alu);
        chk("dmem_wdata", dmem.dmem_wdata, in.wd);
      end
      @(posedge clk);
      #1;
      if (c < nstall) begin
        chk("stall_bubble", {31'b0, RegWrite_out}, 32'd0);
        chk("req_held", {31'b0, dmem.dmem_req}, 32'd1);
      end else begin
        exp_err = exp_err | mis | tmo;
        chk("bus_error", {31'b0, bus_error}, {31'b0, exp_err});
        chk("req_done", {31'b0, dmem.dmem_req}, 32'd0);
        chk("RegWrite_out", {31'b0, RegWrite_out}, {31'b0, done && in.rw});
        if (done) begin
          chk("MemtoReg_out", {30'b0, MemtoReg_out}, {30'b0, in.mt});
          chk("ALU_result_out", ALU_result_out, in.alu);
          chk("mem_read_data_out", mem_read_data_out, rdv);
          chk("PC_plus_4_out", PC_plus_4_out, in.pc4);
          chk("Rd_out", {27'b0, MEM_WB_RegisterRd_out}, {27'b0, in.rd});
        end
      end
    end
    if (acc && !tmo && wr) dmodel[in.alu] = in.wd;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_req", {31'b0, dmem.dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem.dmem_we}, 32'd0);
    chk("rst_addr", dmem.dmem_addr, 32'd0);
    chk("rst_wdata", dmem.dmem_wdata, 32'd0);
    chk("rst_bus_error", {31'b0, bus_error}, 32'd0);
    chk("rst_RegWrite", {31'b0, RegWrite_out}, 32'd0);
    chk("rst_ALU_out", ALU_result_out, 32'd0);
    chk("rst_rdata_out", mem_read_data_out, 32'd0);
    chk("rst_pc4_out", PC_plus_4_out, 32'd0);
    chk("rst_Rd_out", {27'b0, MEM_WB_RegisterRd_out}, 32'd0);
    apply(nop());
    dmem.dmem_ack = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic instr_t rand_instr();
    instr_t n;
    int unsigned kind;
    n = nop();
    kind = $urandom_range(0, 9);
    n.rw = 1'($urandom); n.mt = 2'($urandom); n.rd = 5'($urandom);
    n.pc4 = $urandom; n.jaddr = $urandom; n.baddr = $urandom; n.wd = $urandom;
    n.zero = 1'($urandom);
    n.alu = 32'($urandom_range(0, 63)) << 2;
    case (kind)
      0, 1, 2: n.alu = $urandom;
      3, 4: begin n.br = 1'($urandom); n.j = 1'($urandom); n.alu = $urandom; end
      5, 6: n.mr = 1'b1;
      7:    n.mw = 1'b1;
      8:    begin n.mr = 1'b1; n.mw = 1'b1; end
      default: begin n.mr = 1'($urandom); n.mw = ~n.mr; n.alu = n.alu | 32'($urandom_range(1, 3)); end
    endcase
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    rst = 1'b0;
    apply(nop());
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;
    #2;
    chk("reset_req", {31'b0, dmem.dmem_req}, 32'd0);
    chk("reset_RegWrite", {31'b0, RegWrite_out}, 32'd0);
    chk("reset_bus_error", {31'b0, bus_error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU op
    t = nop(); t.rw = 1; t.alu = 32'h1234; t.rd = 5'd5; t.pc4 = 32'h10;
    run_instr(t, 1);
    // Load, ack 3 cycles after request
    dmodel[32'h40] = 32'hDEAD_BEEF;
    t = nop(); t.rw = 1; t.mt = 2'b01; t.mr = 1; t.alu = 32'h40; t.rd = 5'd7;
    run_instr(t, 3);
    // Store, ack on first request cycle
    t = nop(); t.mw = 1; t.alu = 32'h80; t.wd = 32'hA5A5_A5A5;
    run_instr(t, 1);
    // Misaligned load
    t = nop(); t.rw = 1; t.mt = 2'b01; t.mr = 1; t.alu = 32'h42; t.rd = 5'd3;
    run_instr(t, 1);
    // Reset in the middle of an outstanding store
    t = nop(); t.mw = 1; t.alu = 32'h88; t.wd = 32'h1234_5678;
    @(negedge clk);
    apply(t);
    dmem.dmem_ack = 1'b0;
    @(posedge clk);
    #1 chk("midaccess_req", {31'b0, dmem.dmem_req}, 32'd1);
    @(negedge clk);
    pulse_reset();
    t = nop(); t.rw = 1; t.alu = 32'h55; t.rd = 5'd9;
    run_instr(t, 1);
    // Timeout: no ack within T cycles, then ack on the very last allowed cycle
    t = nop(); t.rw = 1; t.mt = 2'b01; t.mr = 1; t.alu = 32'h44; t.rd = 5'd2;
    run_instr(t, T + 2);
    run_instr(t, T);
    // Branch taken, then jump overriding branch target
    t = nop(); t.br = 1; t.zero = 1; t.baddr = 32'h100;
    run_instr(t, 1);
    t.j = 1; t.jaddr = 32'h200;
    run_instr(t, 1);
    t = nop(); t.br = 1; t.zero = 0; t.baddr = 32'h300;
    run_instr(t, 1);

    for (int i = 0; i < 240; i++) begin
      if (i % 60 == 59) pulse_reset();
      run_instr(rand_instr(), $urandom_range(1, T + 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
